sram_arbiter: RTL and testbench

Two-requester access controller for the parameterized single-port SRAM extension macro (`sram_extension_param`). It grants ports A and B round-robin, launches one SRAM access per cycle through registered memory-side outputs, and routes read-data-valid back to the requester that issued the read. It sits directly in front of the SRAM extension instance; the chip-select decode stays inside that macro.

---
 rtl/sram_arb_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 36 +++
 rtl/sram_arbiter.sv | 118 +++++++++++
 tb/tb_sram_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM access arbiter.
// Port ids, read-return tag layout and latency bound.
package sram_arb_pkg;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int MAX_RD_LATENCY = 4;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter with one-hot grant.
// Bit 0 is port A, bit 1 is port B.
module rr_arbiter2
  import sram_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);

  logic last_q;

  always_comb begin
    o_gnt = 2'b00;
    unique case (1'b1)
      (i_req == 2'b11): begin
        o_gnt = (last_q == PORT_B) ? 2'b01 : 2'b10;
      end
      (i_req == 2'b01): o_gnt = 2'b01;
      (i_req == 2'b10): o_gnt = 2'b10;
      default:          o_gnt = 2'b00;
    endcase
  end

  // Pointer moves only when a grant is actually taken.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      last_q <= PORT_B;
    end else if (i_accept) begin
      last_q <= o_gnt[1] ? PORT_B : PORT_A;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin front end for the single-port SRAM extension macro.
// Registers one access per cycle and routes read-valid to its owner.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int BW_DATA    = 64,
  parameter int BW_ADDR    = 6,
  parameter int RD_LATENCY = 1
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_a_req,
  input  logic               i_a_we,
  input  logic [BW_ADDR-1:0] i_a_addr,
  input  logic [BW_DATA-1:0] i_a_wdata,
  output logic               o_a_gnt,
  output logic               o_a_rvalid,
  output logic [BW_DATA-1:0] o_a_rdata,
  input  logic               i_b_req,
  input  logic               i_b_we,
  input  logic [BW_ADDR-1:0] i_b_addr,
  input  logic [BW_DATA-1:0] i_b_wdata,
  output logic               o_b_gnt,
  output logic               o_b_rvalid,
  output logic [BW_DATA-1:0] o_b_rdata,
  output logic [BW_ADDR-1:0] o_mem_addr,
  output logic [BW_DATA-1:0] o_mem_data,
  output logic               o_mem_wen,
  output logic               o_mem_oen,
  input  logic [BW_DATA-1:0] i_mem_data,
  output logic               o_busy
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic       accept;
  logic       sel;
  logic       sel_we;
  logic       busy_d;
  rd_tag_t    acc_tag;
  rd_tag_t    tag_q [RD_LATENCY];

  assign req = {i_b_req, i_a_req};

  rr_arbiter2 u_arb (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_req    (req),
    .i_accept (accept),
    .o_gnt    (gnt)
  );

  assign o_a_gnt = gnt[0];
  assign o_b_gnt = gnt[1];
  assign accept  = |gnt;
  assign sel     = gnt[1];
  assign sel_we  = sel ? i_b_we : i_a_we;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_mem_addr <= '0;
      o_mem_data <= '0;
      o_mem_wen  <= 1'b1;
      o_mem_oen  <= 1'b1;
      acc_tag    <= '0;
    end else begin
      o_mem_wen <= 1'b1;
      o_mem_oen <= 1'b1;
      acc_tag   <= '0;
      if (accept) begin
        o_mem_addr    <= sel ? i_b_addr : i_a_addr;
        o_mem_data    <= sel ? i_b_wdata : i_a_wdata;
        o_mem_wen     <= ~sel_we;
        o_mem_oen     <= sel_we;
        acc_tag.valid <= ~sel_we;
        acc_tag.id    <= sel;
      end
    end
  end

  // Tag trails the access cycle by RD_LATENCY stages.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= acc_tag;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    busy_d = accept | acc_tag.valid;
    for (int i = 0; i < RD_LATENCY - 1; i++) begin
      busy_d = busy_d | tag_q[i].valid;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_busy <= 1'b0;
    end else begin
      o_busy <= busy_d;
    end
  end

  assign o_a_rvalid = tag_q[RD_LATENCY-1].valid &
                      (tag_q[RD_LATENCY-1].id == PORT_A);
  assign o_b_rvalid = tag_q[RD_LATENCY-1].valid &
                      (tag_q[RD_LATENCY-1].id == PORT_B);

  assign o_a_rdata = i_mem_data;
  assign o_b_rdata = i_mem_data;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: latency 1 and latency 3 instances.
// Behavioural SRAM models sit behind each instance.
module tb_sram_arbiter;

  localparam logic [63:0] V2A = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] V00 = 64'h1000_0000_0000_0000;
  localparam logic [63:0] V0F = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [63:0] V10 = 64'h1010_1010_1010_1010;
  localparam logic [63:0] V3F = 64'h3F3F_3F3F_3F3F_3F3F;
  localparam logic [63:0] VA5 = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] VB0 = 64'hB0B0_B0B0_B0B0_B0B0;
  localparam logic [63:0] V66 = 64'h6666_0000_6666_0000;
  localparam logic [63:0] V20 = 64'h2020_2020_2020_2020;
  localparam logic [63:0] VF0 = 64'hFEED_FACE_CAFE_F00D;

  logic        clk = 1'b0;
  logic        rstn;

  logic        a_req, a_we, b_req, b_we;
  logic [5:0]  a_addr, b_addr;
  logic [63:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [63:0] a_rdata, b_rdata;
  logic [5:0]  mem_addr;
  logic [63:0] mem_data, mem_rdata;
  logic        mem_wen, mem_oen, busy;

  logic        a3_req, a3_we, b3_req, b3_we;
  logic [5:0]  a3_addr, b3_addr;
  logic [63:0] a3_wdata, b3_wdata;
  logic        a3_gnt, a3_rvalid, b3_gnt, b3_rvalid;
  logic [63:0] a3_rdata, b3_rdata;
  logic [5:0]  m3_addr;
  logic [63:0] m3_data, m3_rdata;
  logic        m3_wen, m3_oen, busy3;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic        rv_v [8];
  logic        rv_p [8];
  logic [63:0] rv_d [8];
  logic        pg, pwe, prd2;
  logic [5:0]  pa;
  logic [63:0] pd;

  always #5 clk = ~clk;

  sram_arbiter #(.BW_DATA(64), .BW_ADDR(6), .RD_LATENCY(1)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_a_req(a_req), .i_a_we(a_we),
    .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_gnt(a_gnt), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata),
    .i_b_req(b_req), .i_b_we(b_we),
    .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata),
    .o_mem_addr(mem_addr), .o_mem_data(mem_data),
    .o_mem_wen(mem_wen), .o_mem_oen(mem_oen),
    .i_mem_data(mem_rdata), .o_busy(busy)
  );

  sram_arbiter #(.BW_DATA(64), .BW_ADDR(6), .RD_LATENCY(3)) dut3 (
    .i_clk(clk), .i_rstn(rstn),
    .i_a_req(a3_req), .i_a_we(a3_we),
    .i_a_addr(a3_addr), .i_a_wdata(a3_wdata),
    .o_a_gnt(a3_gnt), .o_a_rvalid(a3_rvalid), .o_a_rdata(a3_rdata),
    .i_b_req(b3_req), .i_b_we(b3_we),
    .i_b_addr(b3_addr), .i_b_wdata(b3_wdata),
    .o_b_gnt(b3_gnt), .o_b_rvalid(b3_rvalid), .o_b_rdata(b3_rdata),
    .o_mem_addr(m3_addr), .o_mem_data(m3_data),
    .o_mem_wen(m3_wen), .o_mem_oen(m3_oen),
    .i_mem_data(m3_rdata), .o_busy(busy3)
  );

  // SRAM models: write on wen low, read data after 1 or 3 edges.
  logic [63:0] mem1 [64];
  logic [63:0] mem3 [64];
  logic [63:0] rd1, s1, s2, s3;

  always @(posedge clk) begin
    if (!mem_wen) mem1[mem_addr] <= mem_data;
    rd1 <= mem1[mem_addr];
    if (!m3_wen) mem3[m3_addr] <= m3_data;
    s1 <= mem3[m3_addr];
    s2 <= s1;
    s3 <= s2;
  end

  assign mem_rdata = rd1;
  assign m3_rdata  = s3;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // eg: expected grant 0 none, 1 A, 2 B; erd: data for a granted read.
  task automatic run_cycle(
    input logic ar, input logic aw,
    input logic [5:0] aa, input logic [63:0] ad,
    input logic br, input logic bw,
    input logic [5:0] ba, input logic [63:0] bd,
    input int eg, input logic [63:0] erd);
    int s;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
    chk("a_gnt", a_gnt, eg == 1);
    chk("b_gnt", b_gnt, eg == 2);
    chk("mem_wen", mem_wen, !(pg && pwe));
    chk("mem_oen", mem_oen, !(pg && !pwe));
    if (pg) begin
      chk("mem_addr", mem_addr, pa);
      chk("mem_data", mem_data, pd);
    end
    chk("busy", busy, pg || prd2);
    s = cyc % 8;
    chk("a_rvalid", a_rvalid, rv_v[s] && !rv_p[s]);
    chk("b_rvalid", b_rvalid, rv_v[s] && rv_p[s]);
    if (rv_v[s] && !rv_p[s]) chk("a_rdata", a_rdata, rv_d[s]);
    if (rv_v[s] && rv_p[s]) chk("b_rdata", b_rdata, rv_d[s]);
    rv_v[s] = 1'b0;
    prd2 = pg && !pwe;
    pg = (eg != 0);
    pwe = (eg == 2) ? bw : aw;
    pa = (eg == 2) ? ba : aa;
    pd = (eg == 2) ? bd : ad;
    if (pg && !pwe) begin
      rv_v[(cyc + 2) % 8] = 1'b1;
      rv_p[(cyc + 2) % 8] = (eg == 2);
      rv_d[(cyc + 2) % 8] = erd;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    rstn = 1'b0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    a3_req = 0; a3_we = 0; a3_addr = 0; a3_wdata = 0;
    b3_req = 0; b3_we = 0; b3_addr = 0; b3_wdata = 0;
    pg = 0; pwe = 0; prd2 = 0; pa = 0; pd = 0;
    for (int i = 0; i < 8; i++) begin
      rv_v[i] = 0; rv_p[i] = 0; rv_d[i] = 0;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", mem_wen, 1);
    chk("rst_oen", mem_oen, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst3_oen", m3_oen, 1);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // single port write then read
    run_cycle(1, 1, 6'h2A, V2A, 0, 0, 0, 0, 1, 0);
    run_cycle(1, 0, 6'h2A, 0, 0, 0, 0, 0, 1, V2A);
    idle(3);

    // address extremes, alternating ports, back to back
    run_cycle(1, 1, 6'h00, V00, 0, 0, 0, 0, 1, 0);
    run_cycle(0, 0, 0, 0, 1, 1, 6'h0F, V0F, 2, 0);
    run_cycle(1, 1, 6'h10, V10, 0, 0, 0, 0, 1, 0);
    run_cycle(0, 0, 0, 0, 1, 1, 6'h3F, V3F, 2, 0);
    run_cycle(1, 0, 6'h00, 0, 0, 0, 0, 0, 1, V00);
    run_cycle(0, 0, 0, 0, 1, 0, 6'h0F, 0, 2, V0F);
    run_cycle(1, 0, 6'h10, 0, 0, 0, 0, 0, 1, V10);
    run_cycle(0, 0, 0, 0, 1, 0, 6'h3F, 0, 2, V3F);
    idle(3);

    // contention: both request, grants alternate from A
    run_cycle(1, 1, 6'h05, VA5, 1, 0, 6'h2A, 0, 1, 0);
    run_cycle(1, 0, 6'h05, 0, 1, 0, 6'h2A, 0, 2, V2A);
    run_cycle(1, 0, 6'h05, 0, 1, 1, 6'h15, VB0, 1, VA5);
    run_cycle(1, 1, 6'h06, V66, 1, 1, 6'h15, VB0, 2, 0);
    run_cycle(1, 1, 6'h06, V66, 1, 0, 6'h05, 0, 1, 0);
    run_cycle(1, 0, 6'h15, 0, 1, 0, 6'h05, 0, 2, VA5);
    run_cycle(1, 0, 6'h15, 0, 1, 0, 6'h06, 0, 1, VB0);
    run_cycle(1, 0, 6'h00, 0, 1, 0, 6'h06, 0, 2, V66);
    run_cycle(1, 0, 6'h00, 0, 0, 0, 0, 0, 1, V00);
    idle(3);

    // A loses the tie then drops its request
    run_cycle(1, 0, 6'h3F, 0, 1, 1, 6'h20, V20, 2, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 6'h20, 0, 1, 0, 6'h0F, 0, 1, V20);
    run_cycle(0, 0, 0, 0, 1, 0, 6'h0F, 0, 2, V0F);
    idle(3);

    // latency 3 instance
    a3_req = 1; a3_we = 1; a3_addr = 6'h3F; a3_wdata = VF0;
    #1;
    chk("a3_gnt_wr", a3_gnt, 1);
    @(posedge clk);
    #1;
    a3_we = 0; a3_wdata = 0;
    #1;
    chk("a3_gnt_rd", a3_gnt, 1);
    @(posedge clk);
    #1;
    a3_req = 0;
    for (int j = 1; j <= 5; j++) begin
      chk("a3_rvalid", a3_rvalid, j == 4);
      chk("b3_rvalid", b3_rvalid, 0);
      if (j == 1) chk("a3_oen", m3_oen, 0);
      if (j == 4) chk("a3_rdata", a3_rdata, VF0);
      @(posedge clk);
      #1;
    end

    // reset in the middle of a B read
    b_req = 1; b_we = 0; b_addr = 6'h3F; b_wdata = 0;
    #1;
    chk("mr_b_gnt", b_gnt, 1);
    @(posedge clk);
    #1;
    b_req = 0;
    chk("mr_oen_issued", mem_oen, 0);
    #2;
    rstn = 1'b0;
    #1;
    chk("mr_wen", mem_wen, 1);
    chk("mr_oen", mem_oen, 1);
    chk("mr_addr", mem_addr, 0);
    chk("mr_data", mem_data, 0);
    chk("mr_busy", busy, 0);
    @(posedge clk);
    #1;
    chk("mr_b_rvalid", b_rvalid, 0);
    rstn = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      chk("mr_b_rvalid_after", b_rvalid, 0);
      chk("mr_a_rvalid_after", a_rvalid, 0);
    end

    // pointer back to B after reset: A wins the tie
    a_req = 1; a_we = 0; b_req = 1; b_we = 0;
    #1;
    chk("rst_ptr_a_gnt", a_gnt, 1);
    chk("rst_ptr_b_gnt", b_gnt, 0);
    a_req = 0; b_req = 0;
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
